wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the ARM pipeline. It registers the MEM-stage result, selects the ALU result or the load data, and drives the register-file write port (`destWB`, `resultWB`, `writeBackEn`). It also exports the in-flight destination for hazard/forwarding logic and honours the SRAM-controller freeze and the pipeline flush.

## Interface
Parameters:
- `DW`, 32, datapath width.
- `RW`, 4, register index width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `freeze`  in  1  SRAM-controller stall; hold all state.
- `flush`  in  1  insert a bubble into the stage.
- `mem_valid`  in  1  MEM stage presents a real instruction.
- `mem_wb_en`  in  1  instruction writes a register.
- `mem_r_en`  in  1  instruction is a load (select `mem_data`).
- `mem_dest`  in  RW  destination register index.
- `alu_result`  in  DW  ALU/address result.
- `mem_data`  in  DW  load data from memory.
- `writeBackEn`  out  1  register-file write enable.
- `destWB`  out  RW  register-file write index.
- `resultWB`  out  DW  register-file write data.
- `fwd_valid`  out  1  `destWB` holds a pending write (equals `writeBackEn`).
- `r15_drop`  out  1  one-cycle flag: a write to R15 was discarded.
- `wb_count`  out  32  retired-write counter (see Configuration).

## Operation
- Single pipeline register with priority per rising edge: `rst` > `flush` > `freeze` > capture.
- `rst`: `writeBackEn`=0, `destWB`=0, `resultWB`=0, `r15_drop`=0, `wb_count`=0.
- `flush` (not in reset): capture a bubble. `writeBackEn`=0, `destWB`=0, `resultWB`=0, `r15_drop`=0. `wb_count` is unchanged. Flush overrides freeze.
- `freeze` (no rst/flush): every register holds, except `r15_drop`, which clears to 0 so that it remains a single-cycle pulse.
- Capture:
  - `resultWB` ← `mem_r_en` ? `mem_data` : `alu_result`.
  - `destWB` ← `mem_dest`.
  - `writeBackEn` ← `mem_valid & mem_wb_en & (mem_dest != 4'hF)`.
- R15 guard: the register file has only R0–R14. When a capture has `mem_valid & mem_wb_en & mem_dest==4'hF`:
  - `writeBackEn` is 0.
  - `r15_drop` is 1 for exactly that cycle.
  - `destWB` and `resultWB` still load normally.
- When `mem_valid`=0, a capture loads a bubble with `writeBackEn`=0. Data fields still load and are don't-care.
- While `writeBackEn` is held through a freeze, the register file rewrites the same value every cycle. This is idempotent and is required behaviour.

## Timing
- Latency: MEM inputs sampled at edge N appear on the outputs after edge N. The register file commits them on the following falling edge, i.e. within the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `fwd_valid`/`destWB` are valid for the whole cycle in which the write is pending.
- Reset asserted mid-freeze or mid-write clears the stage on the next edge regardless of other inputs.
- The stage does not backpressure; upstream freeze is the only stall mechanism.

## Configuration
- Macro: `WB_STAGE_COUNT_EN`.
- Defined:
  - `wb_count` increments by 1 on each capture edge where the captured `writeBackEn` is 1.
  - It does not count during freeze, flush, bubbles, or R15 drops.
  - It wraps from 32'hFFFF_FFFF to 0.
  - It clears on `rst`.
- Undefined: the counter logic is absent and `wb_count` is tied to 32'h0.

## Test plan
- Reset, then an ALU write: `rst`=1 for 2 cycles → all outputs 0. Then `mem_valid`=1, `mem_wb_en`=1, `mem_r_en`=0, `mem_dest`=3, `alu_result`=32'h1234 → next cycle `writeBackEn`=1, `destWB`=3, `resultWB`=32'h1234. Register-file R3 reads 32'h1234 one cycle later.
- Load select: `mem_r_en`=1, `alu_result`=32'h100, `mem_data`=32'hDEADBEEF, `mem_dest`=7 → `resultWB`=32'hDEADBEEF, `destWB`=7, `writeBackEn`=1.
- Freeze: assert `freeze` for 3 cycles while inputs change to `mem_dest`=9 / 32'h55 → outputs hold the prior 7 / 32'hDEADBEEF and `wb_count` is unchanged. On release, the next edge captures 9 / 32'h55.
- Flush over freeze: `freeze`=1 and `flush`=1 together with a pending write → next cycle `writeBackEn`=0, `destWB`=0, `resultWB`=0.
- R15 guard: `mem_dest`=4'hF, `mem_wb_en`=1, `mem_valid`=1 → `writeBackEn`=0 and `r15_drop`=1 for exactly one cycle (also with `freeze`=1 on the next cycle). R0–R14 are unchanged.
- With `WB_STAGE_COUNT_EN`: 5 valid writes, 1 bubble, 1 R15 drop, and 2 frozen cycles → `wb_count`=5. Preload the counter to 32'hFFFF_FFFF by force, then one write → `wb_count`=0.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline register for the ARM core. It selects load data or the
//           ALU result and drives the register-file write port.
// Latency:  1 cycle. MEM inputs sampled at edge N appear on the outputs right after edge N.
//           All outputs are registered.
// Backpressure: none is generated. freeze holds the stage. flush inserts a bubble and wins over freeze.
//
// Ports:
//   clk, rst (sync, active-high)    - clock / reset
//   freeze, flush                   - stall / bubble insertion
//   mem_valid, mem_wb_en, mem_r_en  - MEM-stage instruction qualifiers
//   mem_dest, alu_result, mem_data  - MEM-stage payload
//   writeBackEn, destWB, resultWB   - register-file write port
//   fwd_valid                       - pending write in this stage (same as writeBackEn)
//   r15_drop                        - one-cycle pulse: a write to R15 was discarded
//   wb_count                        - retired-write counter
//
// Optional feature: define WB_STAGE_COUNT_EN to build the retired-write counter.
// When it is undefined, wb_count is tied to zero.

module wb_stage #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic          mem_wb_en,
    input  logic          mem_r_en,
    input  logic [RW-1:0] mem_dest,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] mem_data,
    output logic          writeBackEn,
    output logic [RW-1:0] destWB,
    output logic [DW-1:0] resultWB,
    output logic          fwd_valid,
    output logic          r15_drop,
    output logic [31:0]   wb_count
);

    logic          we_q,   we_d;
    logic [RW-1:0] dest_q, dest_d;
    logic [DW-1:0] res_q,  res_d;
    logic          drop_q, drop_d;

    logic capture;
    logic wr_req;
    logic is_r15;

    assign capture = !flush && !freeze;
    assign wr_req  = mem_valid && mem_wb_en;
    // The register file only holds R0-R14, so the all-ones index is not writable.
    assign is_r15  = (mem_dest == {RW{1'b1}});

    always_comb begin
        we_d   = we_q;
        dest_d = dest_q;
        res_d  = res_q;
        // r15_drop clears on every non-capture edge so that it stays a single-cycle pulse.
        drop_d = 1'b0;
        if (flush) begin
            we_d   = 1'b0;
            dest_d = '0;
            res_d  = '0;
        end else if (capture) begin
            we_d   = wr_req && !is_r15;
            dest_d = mem_dest;
            res_d  = mem_r_en ? mem_data : alu_result;
            drop_d = wr_req && is_r15;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            dest_q <= '0;
            res_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            we_q   <= we_d;
            dest_q <= dest_d;
            res_q  <= res_d;
            drop_q <= drop_d;
        end
    end

`ifdef WB_STAGE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Count only edges that actually load a write. Frozen, flushed, bubble and R15 cycles do not count.
    // The counter wraps naturally at 2^32.
    always_comb begin
        cnt_d = cnt_q;
        if (capture && wr_req && !is_r15) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_count = cnt_q;
`else
    assign wb_count = 32'h0;
`endif

    assign writeBackEn = we_q;
    assign fwd_valid   = we_q;
    assign destWB      = dest_q;
    assign resultWB    = res_q;
    assign r15_drop    = drop_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage.
// A reference model computes the expected outputs each time stimulus is driven and queues them.
// After the edge, the bench pops the queue and compares against the DUT outputs.
// A small register-file model commits writes on the falling edge.

module tb_wb_stage;

    typedef struct packed {
        logic        we;
        logic [3:0]  dest;
        logic [31:0] res;
        logic        drop;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, mem_valid, mem_wb_en, mem_r_en;
    logic [3:0]  mem_dest;
    logic [31:0] alu_result, mem_data;
    logic        writeBackEn, fwd_valid, r15_drop;
    logic [3:0]  destWB;
    logic [31:0] resultWB, wb_count;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb_q[$];
    exp_t m;            // model state
    logic [31:0] rf [0:14];
    logic [31:0] rf_snap [0:14];
    logic [31:0] cnt_base;

    always #5 clk = ~clk;

    wb_stage #(.DW(32), .RW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_wb_en  (mem_wb_en),
        .mem_r_en   (mem_r_en),
        .mem_dest   (mem_dest),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .writeBackEn(writeBackEn),
        .destWB     (destWB),
        .resultWB   (resultWB),
        .fwd_valid  (fwd_valid),
        .r15_drop   (r15_drop),
        .wb_count   (wb_count)
    );

    // Register file: R0-R14 commit on the falling edge of the write cycle.
    always @(negedge clk) begin
        if (writeBackEn && destWB != 4'hF) rf[destWB] <= resultWB;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the model's expectation, and compare after the edge.
    task automatic cyc(input logic r, input logic fr, input logic fl, input logic v,
                       input logic we, input logic re, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] md);
        exp_t e;
        rst = r; freeze = fr; flush = fl; mem_valid = v; mem_wb_en = we;
        mem_r_en = re; mem_dest = d; alu_result = a; mem_data = md;

        e = m;
        e.drop = 1'b0;
        if (r) begin
            e = '0;
        end else if (fl) begin
            e.we = 1'b0; e.dest = '0; e.res = '0;
        end else if (!fr) begin
            e.we   = v && we && (d != 4'hF);
            e.drop = v && we && (d == 4'hF);
            e.dest = d;
            e.res  = re ? md : a;
`ifdef WB_STAGE_COUNT_EN
            if (e.we) e.cnt = m.cnt + 32'd1;
`endif
        end
`ifndef WB_STAGE_COUNT_EN
        e.cnt = 32'h0;
`endif
        m = e;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("writeBackEn", {63'd0, writeBackEn}, {63'd0, e.we});
            check("fwd_valid",   {63'd0, fwd_valid},   {63'd0, e.we});
            check("destWB",      {60'd0, destWB},      {60'd0, e.dest});
            check("resultWB",    {32'd0, resultWB},    {32'd0, e.res});
            check("r15_drop",    {63'd0, r15_drop},    {63'd0, e.drop});
            check("wb_count",    {32'd0, wb_count},    {32'd0, e.cnt});
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        m = '0;
        for (int i = 0; i < 15; i++) rf[i] = 32'h0;

        // Reset for two cycles.
        cyc(1, 0, 0, 1, 1, 0, 4'd5, 32'hFFFF, 32'hEEEE);
        cyc(1, 0, 0, 1, 1, 0, 4'd5, 32'hFFFF, 32'hEEEE);

        // ALU write to R3. The register file holds it one cycle later.
        cyc(0, 0, 0, 1, 1, 0, 4'd3, 32'h1234, 32'h9999);
        idle();
        check("rf_r3", {32'd0, rf[3]}, 64'h1234);

        // Load select.
        cyc(0, 0, 0, 1, 1, 1, 4'd7, 32'h100, 32'hDEADBEEF);

        // Freeze for 3 cycles with changed inputs: the stage holds 7 / DEADBEEF.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 1, 0, 4'd9, 32'h55, 32'h0);
        check("frz_dest", {60'd0, destWB}, 64'd7);
        // Release: the stage captures 9 / 55.
        cyc(0, 0, 0, 1, 1, 0, 4'd9, 32'h55, 32'h0);

        // Flush together with freeze while a write is pending: a bubble is inserted.
        cyc(0, 1, 1, 1, 1, 0, 4'd4, 32'h77, 32'h0);
        check("flush_we", {63'd0, writeBackEn}, 64'd0);

        // R15 guard: the write is dropped, the pulse lasts one cycle, and the register file is untouched.
        for (int i = 0; i < 15; i++) rf_snap[i] = rf[i];
        cyc(0, 0, 0, 1, 1, 0, 4'hF, 32'hAAAA, 32'h0);
        cyc(0, 1, 0, 1, 1, 0, 4'hF, 32'hBBBB, 32'h0);
        idle();
        for (int i = 0; i < 15; i++) check("rf_keep", {32'd0, rf[i]}, {32'd0, rf_snap[i]});

        // Counting mix: 5 writes, 1 bubble, 1 R15 drop, 2 frozen cycles.
        cnt_base = m.cnt;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0, 4'(i + 1), 32'(i * 16), 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 4'd2, 32'h1, 32'h0);
        cyc(0, 0, 0, 1, 1, 0, 4'hF, 32'h2, 32'h0);
        cyc(0, 1, 0, 1, 1, 0, 4'd6, 32'h3, 32'h0);
        cyc(0, 1, 0, 1, 1, 0, 4'd6, 32'h3, 32'h0);
`ifdef WB_STAGE_COUNT_EN
        check("cnt_delta5", {32'd0, wb_count - cnt_base}, 64'd5);
        // Preload the counter to the wrap point, then one write wraps it to zero.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m.cnt = 32'hFFFF_FFFF;
        check("cnt_preload", {32'd0, wb_count}, 64'hFFFF_FFFF);
        cyc(0, 0, 0, 1, 1, 0, 4'd1, 32'h42, 32'h0);
        check("cnt_wrap", {32'd0, wb_count}, 64'd0);
`else
        check("cnt_tied0", {32'd0, wb_count}, 64'd0);
`endif

        // Random mix against the model.
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom), $urandom, $urandom);
        end

        // Reset during freeze with a valid write clears the stage.
        cyc(0, 0, 0, 1, 1, 0, 4'd8, 32'h88, 32'h0);
        cyc(1, 1, 0, 1, 1, 0, 4'd8, 32'h99, 32'h0);
        check("rst_frz_we", {63'd0, writeBackEn}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
